// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit:
// op-bit indices, FSM state encoding and the EX hilo bus width.
package ex_muldiv_unit_pkg;

    localparam int MULDIV_MULT  = 3;
    localparam int MULDIV_MULTU = 2;
    localparam int MULDIV_DIV   = 1;
    localparam int MULDIV_DIVU  = 0;

    localparam int DEF_DATA_WD = 32;
    // EX hilo bus layout: {hi_we, hi, lo_we, lo}
    localparam int HILO_WD     = 2 * DEF_DATA_WD + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring-division datapath: one quotient bit per step on unsigned magnitudes.
// quot_o/rem_o present the values after the current step, so the last step's result is visible before its edge.
module muldiv_div_core #(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [DATA_WD-1:0] dividend,
    input  logic [DATA_WD-1:0] divisor,
    output logic [DATA_WD-1:0] quot_o,
    output logic [DATA_WD-1:0] rem_o
);
    logic [DATA_WD-1:0] rem_q, rem_d;
    logic [DATA_WD-1:0] quot_q, quot_d;
    logic [DATA_WD-1:0] dsor_q, dsor_d;
    logic [DATA_WD:0]   shifted, diff;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rem_d   = rem_q;
        quot_d  = quot_q;
        dsor_d  = dsor_q;
        shifted = {rem_q, quot_q[DATA_WD-1]};
        diff    = shifted - {1'b0, dsor_q};
        if (start) begin
            rem_d  = '0;
            quot_d = dividend;
            dsor_d = divisor;
        end else if (step) begin
            // diff[MSB] set means the trial subtraction borrowed: restore.
            if (!diff[DATA_WD]) begin
                rem_d  = diff[DATA_WD-1:0];
                quot_d = {quot_q[DATA_WD-2:0], 1'b1};
            end else begin
                rem_d  = shifted[DATA_WD-1:0];
                quot_d = {quot_q[DATA_WD-2:0], 1'b0};
            end
        end
        quot_o = quot_d;
        rem_o  = rem_d;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quot_q <= '0;
            dsor_q <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dsor_q <= dsor_d;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle mult/multu/div/divu unit producing the HI/LO write pair for the EX stage.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single registered multiply.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_WD = 32,
    parameter int CNT_WD  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [DATA_WD-1:0] src1,
    input  logic [DATA_WD-1:0] src2,
    output logic               busy,
    output logic               stall_req,
    output logic               done,
    output logic [DATA_WD-1:0] hi_o,
    output logic [DATA_WD-1:0] lo_o,
    output logic               hilo_we
);
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(DATA_WD - 1);

    muldiv_state_e        state_q, state_d;
    logic [CNT_WD-1:0]    cnt_q, cnt_d;
    logic [DATA_WD-1:0]   mcand_q, mcand_d;
    logic [2*DATA_WD-1:0] prod_q, prod_d;
    logic                 sgn_quot_q, sgn_quot_d;
    logic                 sgn_rem_q, sgn_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [DATA_WD-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic                 accept, sel_mul, sel_signed, mul_last, div_start, div_step;
    logic [DATA_WD-1:0]   mag1, mag2, quot, rem;
    logic [2*DATA_WD-1:0] mul_next, mul_res;

    always_comb begin
        sel_mul    = op[MULDIV_MULT] | op[MULDIV_MULTU];
        sel_signed = op[MULDIV_MULT] | (~op[MULDIV_MULTU] & op[MULDIV_DIV]);
        accept     = (state_q == IDLE) & start & (|op) & ~flush;
        mag1       = (sel_signed & src1[DATA_WD-1]) ? -src1 : src1;
        mag2       = (sel_signed & src2[DATA_WD-1]) ? -src2 : src2;
        div_start  = accept & ~sel_mul;
        div_step   = (state_q == DIV);
    end

`ifdef MULDIV_FAST_MUL_EN
    always_comb begin
        mul_next = {{DATA_WD{1'b0}}, mcand_q} * {{DATA_WD{1'b0}}, prod_q[DATA_WD-1:0]};
        mul_last = 1'b1;
    end
`else
    logic [DATA_WD:0] mul_sum;

    // Multiplier sits in the low half and shifts out LSB-first as the partial sum grows in.
    always_comb begin
        mul_sum  = {1'b0, prod_q[2*DATA_WD-1:DATA_WD]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, prod_q[DATA_WD-1:1]};
        mul_last = (cnt_q == CNT_LAST);
    end
`endif

    muldiv_div_core #(
        .DATA_WD(DATA_WD)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .step     (div_step),
        .dividend (mag1),
        .divisor  (mag2),
        .quot_o   (quot),
        .rem_o    (rem)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        prod_d     = prod_q;
        sgn_quot_d = sgn_quot_q;
        sgn_rem_d  = sgn_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mul_res    = sgn_quot_q ? -mul_next : mul_next;

        case (state_q)
            IDLE: if (accept) begin
                state_d    = sel_mul ? MUL : DIV;
                cnt_d      = '0;
                mcand_d    = mag1;
                prod_d     = {{DATA_WD{1'b0}}, mag2};
                sgn_quot_d = sel_signed & (src1[DATA_WD-1] ^ src2[DATA_WD-1]);
                sgn_rem_d  = sel_signed & src1[DATA_WD-1];
                div_zero_d = (src2 == '0);
            end
            MUL: begin
                prod_d = mul_next;
                cnt_d  = cnt_q + CNT_WD'(1);
                if (mul_last) begin
                    state_d      = DONE;
                    {hi_d, lo_d} = mul_res;
                end
            end
            DIV: begin
                cnt_d = cnt_q + CNT_WD'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    // Divide-by-zero keeps the all-ones quotient regardless of sign.
                    lo_d    = (sgn_quot_q & ~div_zero_q) ? -quot : quot;
                    hi_d    = sgn_rem_q ? -rem : rem;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mcand_q    <= '0;
            prod_q     <= '0;
            sgn_quot_q <= 1'b0;
            sgn_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            prod_q     <= prod_d;
            sgn_quot_q <= sgn_quot_d;
            sgn_rem_q  <= sgn_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE);
        stall_req = accept | (state_q == MUL) | (state_q == DIV);
        done      = (state_q == DONE);
        hilo_we   = done;
        hi_o      = hi_q;
        lo_o      = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit; expected values are hand-computed.
// Honors MULDIV_FAST_MUL_EN for the expected multiply latency.
module tb_ex_muldiv_unit;

    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0001;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 2;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'b0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        busy, stall_req, done, hilo_we;
    logic [31:0] hi_o, lo_o;

    int n_tests = 0;
    int n_fail  = 0;

    ex_muldiv_unit dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .start     (start),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .hilo_we   (hilo_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one op (cycle 0 = the cycle start is sampled) and checks latency, stall and result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc, input bit poke_busy, input bit poke_done);
        int cyc;
        int stall_cnt;
        bit seen;
        @(negedge clk);
        op = o; src1 = a; src2 = b; start = 1'b1;
        #1 check({tag, ".stall0"}, stall_req, 1);
        @(posedge clk); #1;
        start = 1'b0; op = 4'b0; src1 = 32'hdead_beef; src2 = 32'h1234_5678;
        cyc = 1; stall_cnt = 0; seen = 1'b0;
        while (cyc < 100 && !seen) begin
            if (poke_busy && cyc == 3) begin start = 1'b1; op = OP_DIVU; end
            if (poke_busy && cyc == 4) begin start = 1'b0; op = 4'b0; end
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (stall_req) stall_cnt++;
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, ".seen"}, seen, 1);
        check({tag, ".cycle"}, cyc, ecyc);
        check({tag, ".hi"}, hi_o, ehi);
        check({tag, ".lo"}, lo_o, elo);
        check({tag, ".we"}, hilo_we, 1);
        check({tag, ".stall_cnt"}, stall_cnt, ecyc - 1);
        check({tag, ".stall_done"}, stall_req, 0);
        if (poke_done) begin
            start = 1'b1; op = OP_DIVU; src1 = 32'd9; src2 = 32'd2;
            #1 check({tag, ".stall_pokedone"}, stall_req, 0);
        end
        @(posedge clk); #1;
        start = 1'b0; op = 4'b0;
        @(negedge clk);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".idle_done"}, done, 0);
        check({tag, ".hold_hi"}, hi_o, ehi);
        check({tag, ".hold_lo"}, lo_o, elo);
    endtask

    initial begin
        bit saw;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.stall", stall_req, 0);
        check("rst.done", done, 0);
        check("rst.we", hilo_we, 0);
        check("rst.hi", hi_o, 0);
        check("rst.lo", lo_o, 0);
        rst = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_CYC, 0, 0);
        run_op("mult_m7x3", OP_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_CYC, 1, 0);
        run_op("mult_5xm4", OP_MULT, 32'd5, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFEC, MUL_CYC, 0, 0);
        run_op("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, MUL_CYC, 0, 0);
        run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC, 1, 0);
        run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_CYC, 0, 0);
        run_op("divu_7d0", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, DIV_CYC, 0, 1);
        run_op("div_m5d0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_CYC, 0, 0);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIV_CYC, 0, 0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, DIV_CYC, 0, 0);
        run_op("prio_all", 4'b1111, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_CYC, 0, 0);
        run_op("prio_multu", 4'b0110, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, MUL_CYC, 0, 0);
        run_op("prio_div", 4'b0011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC, 0, 0);
        run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, DIV_CYC, 0, 0);

        // Flush a divu at cycle 10; the unit must be idle at cycle 11 with cleared outputs.
        @(negedge clk);
        op = OP_DIVU; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'b0;
        saw = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (done) saw = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush.c10_stall", stall_req, 1);
        check("flush.c10_busy", busy, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        if (done) saw = 1'b1;
        check("flush.no_done", saw, 0);
        check("flush.busy", busy, 0);
        check("flush.stall", stall_req, 0);
        check("flush.hi", hi_o, 0);
        check("flush.lo", lo_o, 0);
        @(posedge clk); #1;
        run_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, DIV_CYC, 0, 0);

        // flush and start together: nothing accepted.
        @(negedge clk);
        op = OP_MULT; src1 = 32'd3; src2 = 32'd3; start = 1'b1; flush = 1'b1;
        #1 check("flush_start.stall", stall_req, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; op = 4'b0;
        @(negedge clk);
        check("flush_start.busy", busy, 0);

        run_op("multu_2p16", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, MUL_CYC, 0, 0);

        // Reset in cycle 1 of a multiply: no done, all outputs zero.
        @(negedge clk);
        op = OP_MULTU; src1 = 32'h0001_0000; src2 = 32'h0001_0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 4'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || hilo_we) saw = 1'b1;
        end
        check("rst_mid.no_done", saw, 0);
        check("rst_mid.busy", busy, 0);
        check("rst_mid.hi", hi_o, 0);
        check("rst_mid.lo", lo_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
